// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and helpers, reused by the sync generator
// and by the drawing stages that need to know where the visible window lies.
package vga_timing_pkg;

    localparam int unsigned COUNT_W = 10;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;

    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    localparam int unsigned H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int unsigned H_SYNC_START = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
    localparam int unsigned V_SYNC_START = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

    typedef logic [COUNT_W-1:0] count_t;

    // Inclusive window test used for the sync pulses.
    function automatic logic in_window(count_t value, count_t first, count_t last);
        return (value >= first) && (value <= last);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N wrap counter with enable; wrap_o flags the enabled step from N-1 back to 0.
module mod_counter #(
    parameter int unsigned Width   = 10,
    parameter int unsigned Modulus = 800
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o,
    output logic             wrap_o
);

    localparam logic [Width-1:0] MaxCount = Width'(Modulus - 1);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        wrap_o  = en_i && (count_q == MaxCount);
        count_d = count_q;
        if (wrap_o) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: stage 1 registers position/sync/blanking from the
// counters, stage 2 gates the drawing stage's colour and realigns syncs to it.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF
) (
    input  logic       pixel_clock,
    input  logic       reset,
    input  logic       red_in,
    input  logic       green_in,
    input  logic       blue_in,
    output logic [9:0] pixel_row,
    output logic [9:0] pixel_col,
    output logic       video_on,
    output logic       h_sync,
    output logic       v_sync,
    output logic       frame_start,
    output logic       vga_red,
    output logic       vga_green,
    output logic       vga_blue,
    output logic       vga_h_sync,
    output logic       vga_v_sync
);

    localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam count_t HVisEnd    = count_t'(H_VISIBLE);
    localparam count_t VVisEnd    = count_t'(V_VISIBLE);
    localparam count_t HSyncFirst = count_t'(H_VISIBLE + H_FRONT);
    localparam count_t HSyncLast  = count_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam count_t VSyncFirst = count_t'(V_VISIBLE + V_FRONT);
    localparam count_t VSyncLast  = count_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    count_t h_count, v_count;
    logic   h_wrap;
    logic   unused_v_wrap;

    mod_counter #(
        .Width  (COUNT_W),
        .Modulus(HTotal)
    ) u_h_counter (
        .clk_i  (pixel_clock),
        .rst_i  (reset),
        .en_i   (1'b1),
        .count_o(h_count),
        .wrap_o (h_wrap)
    );

    mod_counter #(
        .Width  (COUNT_W),
        .Modulus(VTotal)
    ) u_v_counter (
        .clk_i  (pixel_clock),
        .rst_i  (reset),
        .en_i   (h_wrap),
        .count_o(v_count),
        .wrap_o (unused_v_wrap)
    );

    // Stage 1: decode of the current counter position.
    logic video_on_d, h_sync_d, v_sync_d, frame_start_d;

    always_comb begin
        video_on_d    = (h_count < HVisEnd) && (v_count < VVisEnd);
        h_sync_d      = !in_window(h_count, HSyncFirst, HSyncLast);
        v_sync_d      = !in_window(v_count, VSyncFirst, VSyncLast);
        frame_start_d = (h_count == '0) && (v_count == '0);
    end

    count_t row_q, col_q;
    logic   video_on_q, h_sync_q, v_sync_q, frame_start_q;
    logic   vga_red_q, vga_green_q, vga_blue_q, vga_h_sync_q, vga_v_sync_q;

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            row_q         <= '0;
            col_q         <= '0;
            video_on_q    <= 1'b0;
            h_sync_q      <= 1'b1;
            v_sync_q      <= 1'b1;
            frame_start_q <= 1'b0;
            vga_red_q     <= 1'b0;
            vga_green_q   <= 1'b0;
            vga_blue_q    <= 1'b0;
            vga_h_sync_q  <= 1'b1;
            vga_v_sync_q  <= 1'b1;
        end else begin
            row_q         <= v_count;
            col_q         <= h_count;
            video_on_q    <= video_on_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            frame_start_q <= frame_start_d;
            // Stage 2: colour arrives for the stage-1 position, so gate with stage-1 blanking.
            vga_red_q     <= red_in & video_on_q;
            vga_green_q   <= green_in & video_on_q;
            vga_blue_q    <= blue_in & video_on_q;
            vga_h_sync_q  <= h_sync_q;
            vga_v_sync_q  <= v_sync_q;
        end
    end

    assign pixel_row   = row_q;
    assign pixel_col   = col_q;
    assign video_on    = video_on_q;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign frame_start = frame_start_q;
    assign vga_red     = vga_red_q;
    assign vga_green   = vga_green_q;
    assign vga_blue    = vga_blue_q;
    assign vga_h_sync  = vga_h_sync_q;
    assign vga_v_sync  = vga_v_sync_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench: a default-timing instance and a shrunken-timing instance driven together and
// checked every clock against a raster-position model, plus directed timing measurements.
module tb_vga_sync_gen;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb;
    } tim_t;

    typedef struct {
        int row, col, vis, hs, vs, fs, r, g, b, vhs, vvs;
    } exp_t;

    logic clk = 1'b0;
    logic reset, red_in, green_in, blue_in;

    logic [9:0] b_row, b_col, s_row, s_col;
    logic b_vis, b_hs, b_vs, b_fs, b_r, b_g, b_b, b_vhs, b_vvs;
    logic s_vis, s_hs, s_vs, s_fs, s_r, s_g, s_b, s_vhs, s_vvs;

    int n_pass = 0, n_fail = 0, n_total = 0;
    int b_t, s_t;
    exp_t b_exp, s_exp;
    tim_t big_t, small_t;

    always #20 clk = ~clk;

    vga_sync_gen u_big (
        .pixel_clock(clk), .reset(reset),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .pixel_row(b_row), .pixel_col(b_col), .video_on(b_vis),
        .h_sync(b_hs), .v_sync(b_vs), .frame_start(b_fs),
        .vga_red(b_r), .vga_green(b_g), .vga_blue(b_b),
        .vga_h_sync(b_vhs), .vga_v_sync(b_vvs)
    );

    vga_sync_gen #(
        .H_VISIBLE(40), .H_FRONT(4), .H_SYNC(8), .H_BACK(6),
        .V_VISIBLE(30), .V_FRONT(3), .V_SYNC(2), .V_BACK(5)
    ) u_small (
        .pixel_clock(clk), .reset(reset),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .pixel_row(s_row), .pixel_col(s_col), .video_on(s_vis),
        .h_sync(s_hs), .v_sync(s_vs), .frame_start(s_fs),
        .vga_red(s_r), .vga_green(s_g), .vga_blue(s_b),
        .vga_h_sync(s_vhs), .vga_v_sync(s_vvs)
    );

    function automatic exp_t reset_exp();
        exp_t e;
        e = '{row: 0, col: 0, vis: 0, hs: 1, vs: 1, fs: 0, r: 0, g: 0, b: 0, vhs: 1, vvs: 1};
        return e;
    endfunction

    // t = clock edges since reset release; the raster position shown is t-1 into the frame.
    function automatic exp_t advance(tim_t tm, exp_t prev, int t, logic [2:0] rgb);
        exp_t e;
        int ht, vt, p, row, col;
        ht    = tm.hv + tm.hf + tm.hs + tm.hb;
        vt    = tm.vv + tm.vf + tm.vs + tm.vb;
        p     = (t - 1) % (ht * vt);
        row   = p / ht;
        col   = p % ht;
        e.row = row;
        e.col = col;
        e.vis = (col < tm.hv && row < tm.vv) ? 1 : 0;
        e.hs  = (col >= tm.hv + tm.hf && col < tm.hv + tm.hf + tm.hs) ? 0 : 1;
        e.vs  = (row >= tm.vv + tm.vf && row < tm.vv + tm.vf + tm.vs) ? 0 : 1;
        e.fs  = (p == 0) ? 1 : 0;
        e.r   = rgb[2] ? prev.vis : 0;
        e.g   = rgb[1] ? prev.vis : 0;
        e.b   = rgb[0] ? prev.vis : 0;
        e.vhs = prev.hs;
        e.vvs = prev.vs;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic compare(input string who, input exp_t e, input logic [9:0] row, col,
                           input logic vis, hs, vs, fs, r, g, bl, vhs, vvs);
        check({who, ".pixel_row"}, 32'(row), e.row);
        check({who, ".pixel_col"}, 32'(col), e.col);
        check({who, ".video_on"}, 32'(vis), e.vis);
        check({who, ".h_sync"}, 32'(hs), e.hs);
        check({who, ".v_sync"}, 32'(vs), e.vs);
        check({who, ".frame_start"}, 32'(fs), e.fs);
        check({who, ".vga_red"}, 32'(r), e.r);
        check({who, ".vga_green"}, 32'(g), e.g);
        check({who, ".vga_blue"}, 32'(bl), e.b);
        check({who, ".vga_h_sync"}, 32'(vhs), e.vhs);
        check({who, ".vga_v_sync"}, 32'(vvs), e.vvs);
    endtask

    task automatic tick(input logic rst, input logic [2:0] rgb);
        reset = rst;
        {red_in, green_in, blue_in} = rgb;
        @(posedge clk);
        #1;
        if (rst) begin
            b_t = 0;
            s_t = 0;
            b_exp = reset_exp();
            s_exp = reset_exp();
        end else begin
            b_t++;
            s_t++;
            b_exp = advance(big_t, b_exp, b_t, rgb);
            s_exp = advance(small_t, s_exp, s_t, rgb);
        end
        compare("big", b_exp, b_row, b_col, b_vis, b_hs, b_vs, b_fs, b_r, b_g, b_b, b_vhs, b_vvs);
        compare("small", s_exp, s_row, s_col, s_vis, s_hs, s_vs, s_fs, s_r, s_g, s_b, s_vhs,
                s_vvs);
    endtask

    function automatic logic [2:0] rnd_rgb();
        return 3'($urandom_range(0, 7));
    endfunction

    initial begin
        int hs_low, first_hs_col, vis_cnt, red_cnt, found, gap, fs_gap, vs_low, wraps;
        int prow, pcol, vhs_low;
        big_t   = '{640, 16, 96, 48, 480, 10, 2, 33};
        small_t = '{40, 4, 8, 6, 30, 3, 2, 5};

        // Reset with random colour inputs: everything must sit at reset values.
        for (int i = 0; i < 3; i++) tick(1'b1, rnd_rgb());

        // First edge out of reset shows (0,0), visible, frame_start.
        tick(1'b0, 3'b111);
        check("release.frame_start", 32'(b_fs), 1);
        check("release.video_on", 32'(b_vis), 1);
        check("release.row_col", {b_row, b_col}, 0);

        // One default line with all colours held high.
        hs_low = 0; first_hs_col = -1; vis_cnt = 0; red_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            tick(1'b0, 3'b111);
            if (!b_hs) begin
                hs_low++;
                if (first_hs_col < 0) first_hs_col = int'(b_col);
            end
            if (b_vis) vis_cnt++;
            if (b_r) red_cnt++;
        end
        check("line.hsync_low_clocks", hs_low, 96);
        check("line.hsync_first_col", first_hs_col, 656);
        check("line.video_on_clocks", vis_cnt, 640);
        check("line.red_on_clocks", red_cnt, 640);

        // Alignment: red pulse at column 100, then distance to the connector sync edge.
        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            tick(1'b0, 3'b000);
            if (b_col == 10'd100) found = 1;
        end
        check("align.reach_col100", found, 1);
        tick(1'b0, 3'b100);
        check("align.red_pulse", 32'(b_r), 1);
        gap = 0; found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            tick(1'b0, 3'b000);
            gap++;
            if (!b_vhs) found = 1;
        end
        check("align.vga_hsync_found", found, 1);
        check("align.vga_hsync_gap", gap, 556);

        // Small-timing frame: period, vsync width, colour gating and joint wrap.
        found = 0;
        for (int i = 0; i < 3000 && found == 0; i++) begin
            tick(1'b0, rnd_rgb());
            if (s_fs) found = 1;
        end
        check("frame.first_pulse", found, 1);
        fs_gap = -1; vs_low = 0; red_cnt = 0; wraps = 0;
        for (int i = 1; i <= 2320; i++) begin
            prow = int'(s_row);
            pcol = int'(s_col);
            tick(1'b0, 3'b111);
            if (s_fs && fs_gap < 0) fs_gap = i;
            if (!s_vs) vs_low++;
            if (s_r) red_cnt++;
            if (prow == 39 && s_row == 10'd0) begin
                wraps++;
                check("frame.col_wrap_with_row", {pcol[9:0], s_col}, {10'd57, 10'd0});
            end
        end
        check("frame.frame_start_period", fs_gap, 58 * 40);
        check("frame.vsync_low_clocks", vs_low, 2 * 58);
        check("frame.red_on_clocks", red_cnt, 40 * 30);
        check("frame.row_wraps", wraps, 1);

        // Mid-frame reset on the small instance.
        found = 0;
        for (int i = 0; i < 3000 && found == 0; i++) begin
            tick(1'b0, rnd_rgb());
            if (s_row == 10'd20 && s_col == 10'd30) found = 1;
        end
        check("midreset.reach_position", found, 1);
        vhs_low = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 3'b111);
            if (!s_vhs) vhs_low++;
        end
        check("midreset.held_row_col", {s_row, s_col}, 0);
        tick(1'b0, rnd_rgb());
        check("midreset.restart_frame_start", 32'(s_fs), 1);
        check("midreset.restart_row_col", {s_row, s_col}, 0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, rnd_rgb());
            if (!s_vhs) vhs_low++;
        end
        check("midreset.vga_hsync_glitch", vhs_low, 0);

        // Free run with random colours.
        for (int i = 0; i < 3000; i++) tick(1'b0, rnd_rgb());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
